// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the sequential ALU.
//   DEFAULT_WIDTH : default operand/result width
//   OP_*          : 3-bit opcode encodings
//   state_e       : controller state encoding
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle ALU slice (ADD/SUB/AND/OR) with flag generation.
// Any opcode it does not execute yields result 0, arithmetic flags 0, err 1;
// the parent overrides that for the multi-cycle ops it runs itself.
//   a, b      : operands
//   op        : opcode
//   result    : combinational result
//   carry     : carry-out (SUB: 1 = no borrow)
//   overflow  : signed overflow
//   zero      : result == 0
//   negative  : result MSB
//   err       : opcode not handled here
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  always_comb begin
    sub = (op == OP_SUB);
    // SUB is a + ~b + 1 so one adder serves both; the overflow test then
    // works on the effective addend bx for either op.
    bx  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    err      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: err = 1'b1;
    endcase

    zero     = (result == '0);
    negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// ADD/SUB/AND/OR, zero-amount shifts and the reserved opcode finish in one
// cycle; shifts step one bit per EXEC cycle; MUL is shift-add over WIDTH
// EXEC cycles.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier; without it
// opcode 110 behaves as reserved (err = 1).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, op            : operands / opcode, sampled on accept only
//   out_valid, out_ready: result handshake
//   result, carry, overflow, zero, negative, err : registered outputs
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// EXEC  | shift / multiply stepping, cnt_q counts remaining steps down
// DONE  | result valid, held until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e state_q, state_nxt;
  logic   accept;
  logic   tc;
  logic   single_op;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_val_q;
  logic             sh_left_q;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_co_nxt;

  logic [WIDTH-1:0] c_result;
  logic             c_carry, c_overflow, c_zero, c_negative, c_err;

  logic [WIDTH-1:0] sc_result;
  logic             sc_carry, sc_overflow, sc_zero, sc_negative, sc_err;

  logic [WIDTH-1:0] fin_result;
  logic             fin_carry;

`ifdef ALU_SEQ_MUL_EN
  logic               mul_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_nxt;
`endif

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (c_result),
    .carry    (c_carry),
    .overflow (c_overflow),
    .zero     (c_zero),
    .negative (c_negative),
    .err      (c_err)
  );

  assign tc = (cnt_q == CW'(1));

  always_comb begin
    single_op = 1'b1;
    case (op)
      OP_SHL, OP_SHR: single_op = (b[SHW-1:0] == '0);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:         single_op = 1'b0;
`endif
      default:        single_op = 1'b1;
    endcase
  end

  // Zero-amount shifts pass a through; everything else single-cycle comes
  // from the comb slice (which also flags the reserved opcodes).
  always_comb begin
    sc_result   = c_result;
    sc_carry    = c_carry;
    sc_overflow = c_overflow;
    sc_zero     = c_zero;
    sc_negative = c_negative;
    sc_err      = c_err;
    if (op == OP_SHL || op == OP_SHR) begin
      sc_result   = a;
      sc_carry    = 1'b0;
      sc_overflow = 1'b0;
      sc_zero     = (a == '0);
      sc_negative = a[WIDTH-1];
      sc_err      = 1'b0;
    end
  end

  always_comb begin
    sh_nxt     = sh_left_q ? {sh_val_q[WIDTH-2:0], 1'b0} : {1'b0, sh_val_q[WIDTH-1:1]};
    sh_co_nxt  = sh_left_q ? sh_val_q[WIDTH-1] : sh_val_q[0];
    fin_result = sh_nxt;
    fin_carry  = sh_co_nxt;
`ifdef ALU_SEQ_MUL_EN
    prod_nxt = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    if (mul_q) begin
      fin_result = prod_nxt[WIDTH-1:0];
      fin_carry  = |prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = single_op ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      err       <= 1'b0;
      cnt_q     <= '0;
      sh_val_q  <= '0;
      sh_left_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
`endif
    end else if (accept) begin
      if (single_op) begin
        result   <= sc_result;
        carry    <= sc_carry;
        overflow <= sc_overflow;
        zero     <= sc_zero;
        negative <= sc_negative;
        err      <= sc_err;
      end else begin
        sh_val_q  <= a;
        sh_left_q <= (op == OP_SHL);
        cnt_q     <= CW'(b[SHW-1:0]);
`ifdef ALU_SEQ_MUL_EN
        mul_q     <= (op == OP_MUL);
        mcand_q   <= {{WIDTH{1'b0}}, a};
        mplier_q  <= b;
        prod_q    <= '0;
        if (op == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
      end
    end else if (state_q == ST_EXEC) begin
      cnt_q    <= cnt_q - CW'(1);
      sh_val_q <= sh_nxt;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= prod_nxt;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`endif
      if (tc) begin
        result   <= fin_result;
        carry    <= fin_carry;
        overflow <= 1'b0;
        zero     <= (fin_result == '0);
        negative <= fin_result[WIDTH-1];
        err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  logic         carry, overflow, zero, negative, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .err       (err)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       e;
    int         lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accept edge, then scramble inputs.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    tick();
    in_valid = 1'b0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int  lat;
    logic seen;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_OR,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_SHL, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vecs[7]  = '{OP_SHR, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{OP_SHL, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{OP_SHR, 8'hC0, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8};
`ifdef ALU_SEQ_MUL_EN
    vecs[10] = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9};
`else
    vecs[10] = '{OP_MUL, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
`endif
    vecs[11] = '{OP_RSV, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[12] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{OP_AND, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) tick();
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result",    {24'b0, result},    32'd0);
    chk("rst_flags", {27'b0, carry, overflow, zero, negative, err}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i),  lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i),   {24'b0, result},   {24'b0, vecs[i].res});
      chk($sformatf("v%0d_carry", i),    {31'b0, carry},    {31'b0, vecs[i].c});
      chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d_zero", i),     {31'b0, zero},     {31'b0, vecs[i].z});
      chk($sformatf("v%0d_negative", i), {31'b0, negative}, {31'b0, vecs[i].n});
      chk($sformatf("v%0d_err", i),      {31'b0, err},      {31'b0, vecs[i].e});
      chk($sformatf("v%0d_in_ready_done", i), {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_out_valid_after", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("v%0d_in_ready_after", i),  {31'b0, in_ready},  32'd1);
    end

    // Result held under back-pressure while in_valid pulses are ignored.
    issue(OP_ADD, 8'h7F, 8'h01);
    wait_valid(lat);
    chk("hold_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = OP_SUB;
      tick();
      chk($sformatf("hold%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_in_ready", k),  {31'b0, in_ready},  32'd0);
      chk($sformatf("hold%0d_result", k),    {24'b0, result},    32'h80);
      chk($sformatf("hold%0d_flags", k), {27'b0, carry, overflow, zero, negative, err}, 32'b01010);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_release_in_ready",  {31'b0, in_ready},  32'd1);
    tick();
    chk("hold_no_stray_accept", {31'b0, out_valid}, 32'd0);

    // Reset three cycles into a multi-cycle op aborts it.
`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 8'h10, 8'h11);
`else
    issue(OP_SHL, 8'hFF, 8'h07);
`endif
    tick();
    tick();
    chk("abort_in_exec", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result",    {24'b0, result},    32'd0);
    chk("abort_flags", {27'b0, carry, overflow, zero, negative, err}, 32'd0);
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_late_output", {31'b0, seen}, 32'd0);

    // Reset wins over out_ready and in_valid while in DONE.
    issue(OP_ADD, 8'h7F, 8'h01);
    wait_valid(lat);
    chk("done_rst_latency", lat, 1);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("done_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("done_rst_result",    {24'b0, result},    32'd0);
    chk("done_rst_flags", {27'b0, carry, overflow, zero, negative, err}, 32'd0);
    chk("done_rst_in_ready",  {31'b0, in_ready},  32'd1);
    tick();
    chk("done_rst_no_accept", {31'b0, out_valid}, 32'd0);

    // Reserved opcode right after reset.
    issue(OP_RSV, 8'h12, 8'h34);
    wait_valid(lat);
    chk("rsv_latency", lat, 1);
    chk("rsv_err",     {31'b0, err},    32'd1);
    chk("rsv_result",  {24'b0, result}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept; asserted only in IDLE.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR, 110 MUL, 111 reserved.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 carry, overflow, zero, negative, err  output  1 each  registered flags.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; accept when in_valid & in_ready, latching a, b, op.
REQ-014 ADD/SUB/AND/OR and SHL/SHR with shift amount 0 SHALL skip EXEC: out_valid high on the edge after accept (latency 1).
REQ-015 ADD: result = a+b mod 2^WIDTH; carry = bit WIDTH; overflow = signed overflow.
REQ-016 SUB: result = a+~b+1; carry = carry-out (1 = no borrow); overflow = signed overflow of a-b.
REQ-017 AND/OR: bitwise; carry = overflow = 0.
REQ-018 SHL/SHR: logical shift of a by n = b[SHW-1:0], one bit per EXEC cycle; carry = last bit shifted out (0 when n=0); overflow = 0; out_valid n+1 cycles after accept.
REQ-019 MUL: shift-add, WIDTH EXEC cycles; result = low WIDTH bits of a*b (unsigned); carry = 1 if any high product bit nonzero; overflow = 0; out_valid WIDTH+1 cycles after accept.
REQ-020 op 111: result 0, all arithmetic flags 0, err = 1, latency 1; err = 0 for every other op.
REQ-021 zero = (result == 0); negative = result[WIDTH-1]; both registered with result.
REQ-022 In DONE, result and all flags SHALL hold stable while out_valid & ~out_ready.
REQ-023 DONE with out_ready SHALL go to IDLE; new input is never accepted in the same cycle as result handoff (in_ready low in DONE).
REQ-024 Inputs a, b, op SHALL be ignored outside the accept cycle.

Reset
REQ-025 rst SHALL force IDLE, in_ready = 1 on the following cycle, out_valid = 0, result = 0, all flags = 0, internal counters/accumulators cleared.
REQ-026 rst asserted mid-EXEC or in DONE SHALL abort the operation with no output produced; rst has priority over all handshakes.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: defined -> MUL per REQ-019; undefined -> op 110 treated as reserved per REQ-020 and no multiplier datapath synthesised.

Structure
REQ-028 Package alu_seq_pkg SHALL hold opcode constants, FSM state encoding and the default WIDTH constant.
REQ-029 Single-cycle ops (ADD/SUB/AND/OR plus flag generation) SHALL live in sub-module alu_seq_comb; FSM, shifter and multiplier in alu_seq.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 -> result 0x80, carry 0, overflow 1, negative 1, zero 0, out_valid 1 cycle after accept.
REQ-031 SUB a=0x05 b=0x05 -> result 0x00, carry 1, overflow 0, zero 1; SUB a=0x00 b=0x01 -> 0xFF, carry 0, negative 1.
REQ-032 SHL a=0x81 b=0x03 -> result 0x08, carry 0, out_valid 4 cycles after accept; SHR a=0x81 b=0x01 -> 0x40, carry 1, 2 cycles.
REQ-033 MUL a=0x10 b=0x11 (MUL_EN defined) -> result 0x10, carry 1, out_valid 9 cycles after accept; without macro -> result 0, err 1, 1 cycle.
REQ-034 ADD result with out_ready held low 5 cycles -> result/flags stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 rst asserted 3 cycles into MUL -> next cycle out_valid 0, result 0, flags 0, in_ready 1; op 111 -> err 1, result 0.
